// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier issue/capture stage.
package mult_pkg;
    localparam int OPW   = 8;
    localparam int PRODW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding operand pairs; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mult_issue_ctrl.sv
// Issues buffered operand pairs to a sequential multiplier one at a time and captures
// each product into a one-entry output register; a watchdog flags a stuck multiplier.
module mult_issue_ctrl
    import mult_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_a,
    input  logic [7:0]                   in_b,
    output logic                         mul_ld,
    output logic [7:0]                   mul_a,
    output logic [7:0]                   mul_b,
    input  logic [15:0]                  mul_o,
    input  logic                         mul_done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_prod,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         err
);
    localparam int TW = $clog2(TIMEOUT);

    // Streams transfer on a cycle where valid and ready are both high at the rising edge;
    // valid, once raised, is held with stable data until that transfer happens.
    state_t             state;
    logic [TW-1:0]      timer;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*OPW-1:0]   fifo_dout;
    logic               push;
    logic               pop;
    logic               slot_free;
    logic               capture;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign pop       = (state == ST_IDLE) && !fifo_empty && slot_free;
    assign capture   = (state == ST_WAIT) && mul_done;

    sync_fifo #(
        .WIDTH (2*OPW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({in_a, in_b}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            mul_ld    <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            err       <= 1'b0;
        end else begin
            mul_ld <= 1'b0;

            // Issue only starts with a free output slot, so a capture never hits unread data.
            if (capture) begin
                out_valid <= 1'b1;
                out_prod  <= mul_o;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        mul_a  <= fifo_dout[2*OPW-1:OPW];
                        mul_b  <= fifo_dout[OPW-1:0];
                        timer  <= '0;
                        mul_ld <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion on the last allowed cycle still wins over the timeout.
                    if (mul_done) begin
                        state <= ST_IDLE;
                    end else if (timer == TW'(TIMEOUT-1)) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/mult_issue_ctrl.md
# mult_issue_ctrl

Operand issue and result capture stage for the 8x8 sequential shift-add multiplier. Accepts operand pairs over a valid/ready stream, buffers them in a small FIFO, and launches them one at a time on the multiplier's `ld`/`A`/`B` interface. It waits for `Done` and captures the 16-bit product into a one-entry output register presented on a valid/ready stream. A watchdog flags a multiplier that never completes.

## Interface
Parameters:
- `DEPTH`, 4: operand FIFO entries (power of two, ≥2)
- `TIMEOUT`, 32: max cycles in WAIT before error (≥2)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand pair offered
- `in_ready`  out  1  FIFO not full
- `in_a`  in  8  multiplicand
- `in_b`  in  8  multiplier
- `mul_ld`  out  1  one-cycle load pulse to multiplier
- `mul_a`  out  8  operand A to multiplier, held stable through WAIT
- `mul_b`  out  8  operand B to multiplier, held stable through WAIT
- `mul_o`  in  16  multiplier product, valid while `mul_done`=1
- `mul_done`  in  1  multiplier completion pulse
- `out_valid`  out  1  product available
- `out_ready`  in  1  consumer accepts product
- `out_prod`  out  16  captured product
- `fifo_count`  out  $clog2(DEPTH+1)  FIFO occupancy
- `err`  out  1  sticky timeout flag

## Operation
- FIFO push on `in_valid && in_ready`; `in_ready = (fifo_count != DEPTH)`. Push and pop in the same cycle leaves count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, WAIT.
  - IDLE: if FIFO non-empty and `out_valid`=0 (or `out_valid && out_ready` this cycle), pop head into `mul_a`/`mul_b` registers, clear timer, go to LOAD. Otherwise stay.
  - LOAD: `mul_ld`=1 for exactly this cycle; go to WAIT.
  - WAIT: timer increments each cycle. On `mul_done`=1: `out_prod <= mul_o`, `out_valid <= 1`, go to IDLE. If timer reaches TIMEOUT-1 without done: `err <= 1`, operand dropped, go to IDLE.
- `out_valid` clears on `out_ready` when no new capture occurs that cycle. Because issue requires a free output slot, capture never overwrites unread data.
- `mul_done` in IDLE or LOAD is ignored (stray or post-reset completion).
- Arithmetic: no arithmetic in this block; the product is passed through unmodified at 16 bits. Timer width is $clog2(TIMEOUT).

## Timing
- Reset values: `mul_ld`=0, `mul_a`=`mul_b`=0, `out_valid`=0, `out_prod`=0, `err`=0, `fifo_count`=0, `in_ready`=1, state IDLE.
- Pair pushed at edge t: popped at edge t+1 (if idle and slot free). `mul_ld` high during cycle t+1..t+2 (one cycle). WAIT from edge t+2.
- `out_valid` rises on the edge following the cycle in which `mul_done`=1.
- `mul_done` and timeout in the same cycle: done wins, no error.
- Reset mid-operation: FIFO emptied, FSM to IDLE, output and `err` cleared on that edge. The multiplier is not reset by this block; its late `mul_done` is ignored.
- Back-to-back issue: minimum 3 cycles between `mul_ld` pulses beyond the multiplier's own latency (capture, IDLE pop, LOAD).

## Structure
- Package `mult_pkg`: state enum (`ST_IDLE`, `ST_LOAD`, `ST_WAIT`), `OPW=8`, `PRODW=16`.
- Sub-module `sync_fifo` (params WIDTH=16, DEPTH; push/pop/full/empty/count) holds the `{a,b}` pairs. FSM, timer and output register live in the top.

## Test plan
Use a behavioural multiplier model that pulses done N cycles after `ld`.
- Single op, N=10: push (7,9) → exactly one `mul_ld` pulse with `mul_a`=7, `mul_b`=9; `out_prod`=63 with `out_valid` one cycle after done.
- Fill: push 5 pairs with DEPTH=4 and `out_ready`=0 → `in_ready` low at count 4; first product 255*255=65025 held; no second `mul_ld` until the output is accepted.
- Backpressure stream: 8 random pairs with `out_ready` toggling → products in order and all correct; `fifo_count` never exceeds DEPTH.
- Timeout: model never asserts done, TIMEOUT=32 → `err`=1 after 32 WAIT cycles, FSM returns to IDLE, next pair (3,4) yields 12, `err` stays 1.
- Done coincident with timeout (N=TIMEOUT-1 boundary) → product captured, `err`=0.
- Reset in WAIT, then late done: `out_valid` stays 0, count 0, no capture.
